seg_scan_decoder: RTL and testbench

- Monitor and decoder for a time-multiplexed 4-digit 7-segment display bus, i.e. the AN/SEGMENT outputs of the display drivers.
- Samples the bus, waits for each digit to be stable, and decodes the segment pattern back to a hex nibble plus decimal point.
- Collects all four digits into a frame.
- Used as a self-check tap on display outputs, and as the receiving end of a display bus driven from another board.

---
 rtl/seg_dec_pkg.sv | 33 +++
 rtl/seg7_to_hex.sv | 35 +++
 rtl/seg_scan_decoder.sv | 118 +++++++++++
 tb/tb_seg_scan_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg_dec_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment patterns
// for hex digits 0..F and the bit positions of each segment on the bus.
package seg_dec_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_P = 7;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low 7-segment pattern back to a hex nibble.
// ok=0 (nibble 0) for blank or any pattern that is not one of the 16 glyphs.
module seg7_to_hex
    import seg_dec_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       ok
);

    always_comb begin
        nib = 4'h0;
        ok  = 1'b1;
        case (seg)
            SEG_HEX_0: nib = 4'h0;
            SEG_HEX_1: nib = 4'h1;
            SEG_HEX_2: nib = 4'h2;
            SEG_HEX_3: nib = 4'h3;
            SEG_HEX_4: nib = 4'h4;
            SEG_HEX_5: nib = 4'h5;
            SEG_HEX_6: nib = 4'h6;
            SEG_HEX_7: nib = 4'h7;
            SEG_HEX_8: nib = 4'h8;
            SEG_HEX_9: nib = 4'h9;
            SEG_HEX_A: nib = 4'hA;
            SEG_HEX_B: nib = 4'hB;
            SEG_HEX_C: nib = 4'hC;
            SEG_HEX_D: nib = 4'hD;
            SEG_HEX_E: nib = 4'hE;
            SEG_HEX_F: nib = 4'hF;
            default:   ok  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 4-digit active-low 7-segment bus and rebuilds the
// displayed digits. Define SEG_SCAN_DECODER_ERRCNT_EN to enable the error counter.
module seg_scan_decoder
    import seg_dec_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  segment,
    output logic [15:0] digits,
    output logic [3:0]  points,
    output logic [3:0]  dig_ok,
    output logic        frame_pulse,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0] STAB_CAP = 8'(STABLE_CYC - 1);

    logic [SYNC_STAGES-1:0][11:0] syncPipe;
    logic [11:0]      sample, prevSample;
    logic [3:0]       anS;
    logic [7:0]       segS;
    logic [7:0]       stabCnt;
    logic             capDone;
    logic [3:0]       seen, seenSet;
    logic [3:0][3:0]  digitsR;
    logic [1:0]       digIdx;
    logic             oneLow, same, capPoint, capture;
    logic [3:0]       decNib;
    logic             decOk;

    // Index 0 is the newest stage; idle bus is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) syncPipe <= '1;
        else        syncPipe <= {syncPipe[SYNC_STAGES-2:0], an, segment};
    end

    assign sample = syncPipe[SYNC_STAGES-1];
    assign anS    = sample[11:8];
    assign segS   = sample[7:0];

    always_comb begin
        oneLow = 1'b1;
        digIdx = 2'd0;
        case (anS)
            4'hE:    digIdx = 2'd0;
            4'hD:    digIdx = 2'd1;
            4'hB:    digIdx = 2'd2;
            4'h7:    digIdx = 2'd3;
            default: oneLow = 1'b0;
        endcase
    end

    seg7_to_hex uDec (
        .seg (segS[6:0]),
        .nib (decNib),
        .ok  (decOk)
    );

    // The counter saturates past STAB_CAP, so capPoint fires at most once per dwell.
    assign same     = (sample == prevSample);
    assign capPoint = same && (stabCnt == STAB_CAP) && !capDone;
    assign capture  = capPoint && oneLow;
    assign seenSet  = seen | (4'b0001 << digIdx);
    assign digits   = digitsR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevSample  <= '1;
            stabCnt     <= 8'd0;
            capDone     <= 1'b0;
            seen        <= 4'h0;
            digitsR     <= '0;
            points      <= 4'h0;
            dig_ok      <= 4'h0;
            frame_pulse <= 1'b0;
        end else begin
            prevSample  <= sample;
            frame_pulse <= 1'b0;
            if (!same) begin
                stabCnt <= 8'd0;
                capDone <= 1'b0;
            end else if (stabCnt != STAB_MAX) begin
                stabCnt <= stabCnt + 8'd1;
            end
            if (capture) begin
                digitsR[digIdx] <= decNib;
                points[digIdx]  <= ~segS[SEG_P];
                dig_ok[digIdx]  <= decOk;
                capDone         <= 1'b1;
                if (seenSet == 4'hF) begin
                    seen        <= 4'h0;
                    frame_pulse <= 1'b1;
                end else begin
                    seen        <= seenSet;
                end
            end
        end
    end

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
    logic multiLow, errEvent;
    assign multiLow = !oneLow && (anS != 4'hF);
    assign errEvent = capPoint && (multiLow || (oneLow && !decOk));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              err_cnt <= 8'h00;
        else if (errEvent && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed test-plan steps plus random dwells,
// checked every cycle against a dwell-level reference model.
module tb_seg_scan_decoder;

    localparam int SC  = 4;
    localparam int SS  = 2;
    localparam int LAT = SS + SC + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  segment = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  points, dig_ok;
    logic        frame_pulse;
    logic [7:0]  err_cnt;

    seg_scan_decoder #(.STABLE_CYC(SC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .segment(segment),
        .digits(digits), .points(points), .dig_ok(dig_ok),
        .frame_pulse(frame_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] dg;
        logic [3:0]  pt;
        logic [3:0]  ok;
        logic [7:0]  ec;
        logic        fp;
    } upd_t;

    upd_t q[$];
    logic [6:0] hexPat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state (updated at dwell start) and the expected visible outputs.
    logic [15:0] mDg, vDg;
    logic [3:0]  mPt, mOk, mSeen, vPt, vOk;
    logic [7:0]  mEc, vEc;
    logic        vFp;
    logic [3:0]  prevAn;
    logic [7:0]  prevSeg;
    int          cyc = 0;
    int          nCmp = 0;
    int          nFail = 0;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        vFp = 1'b0;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            vDg = q[0].dg; vPt = q[0].pt; vOk = q[0].ok; vEc = q[0].ec; vFp = q[0].fp;
            void'(q.pop_front());
        end
        chk("digits", digits, vDg);
        chk("points", {12'h0, points}, {12'h0, vPt});
        chk("dig_ok", {12'h0, dig_ok}, {12'h0, vOk});
        chk("frame_pulse", {15'h0, frame_pulse}, {15'h0, vFp});
        chk("err_cnt", {8'h0, err_cnt}, {8'h0, vEc});
    endtask

    task automatic modelReset();
        q.delete();
        mDg = '0; mPt = '0; mOk = '0; mSeen = '0; mEc = '0;
        vDg = '0; vPt = '0; vOk = '0; vEc = '0; vFp = 1'b0;
        prevAn = 4'hF; prevSeg = 8'hFF;
    endtask

    task automatic bumpErr();
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
        if (mEc != 8'hFF) mEc++;
`endif
    endtask

    // Hold one bus value for h clocks; consecutive dwells must differ.
    task automatic dwell(logic [3:0] a, logic [7:0] s, int h);
        int   nz, idx;
        logic [3:0] nib;
        logic ok, fp;
        an = a; segment = s;
        prevAn = a; prevSeg = s;
        if (h >= SC + 1 && a != 4'hF) begin
            nz = 0; idx = 0; fp = 1'b0;
            for (int i = 0; i < 4; i++) if (!a[i]) begin nz++; idx = i; end
            if (nz >= 2) begin
                bumpErr();
            end else begin
                nib = 4'h0; ok = 1'b0;
                for (int v = 0; v < 16; v++) if (hexPat[v] == s[6:0]) begin nib = 4'(v); ok = 1'b1; end
                if (!ok) bumpErr();
                mDg[4*idx +: 4] = nib;
                mPt[idx] = ~s[7];
                mOk[idx] = ok;
                mSeen[idx] = 1'b1;
                if (mSeen == 4'hF) begin fp = 1'b1; mSeen = 4'h0; end
            end
            q.push_back('{cyc + LAT, mDg, mPt, mOk, mEc, fp});
        end
        repeat (h) tick();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        for (int i = 0; i < 6; i++) begin
            an = 4'($urandom); segment = 8'($urandom);
            tick();
        end
        an = 4'hF; segment = 8'hFF;
        rst_n = 1'b1;
        repeat (SS + 2) tick();
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;
        logic [3:0] anTab [7] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hC, 4'h5};
        @(negedge clk);

        // 1. reset with toggling inputs
        doReset();

        // 2. normal scan 1,2,3,4
        dwell(4'hE, 8'hF9, 8);
        dwell(4'hD, 8'hA4, 8);
        dwell(4'hB, 8'hB0, 8);
        dwell(4'h7, 8'h99, 8);
        dwell(4'hF, 8'hFF, 8);
        chk("scan_digits", digits, 16'h4321);

        // 3. decimal point and letters
        dwell(4'hE, 8'h08, 8);
        dwell(4'hD, 8'h86, 8);
        dwell(4'hF, 8'hFF, 8);

        // 4. glitch rejection
        dwell(4'hE, 8'hC0, 2);
        dwell(4'hE, 8'hF9, 8);
        dwell(4'hF, 8'hFF, 8);

        // 5. illegal inputs
        dwell(4'hC, 8'hF9, 8);
        dwell(4'hE, 8'hFF, 8);
        dwell(4'hF, 8'hFF, 8);

        // 6. full frame, partial frame, then reset mid-frame
        dwell(4'hE, 8'hC0, 6);
        dwell(4'hD, 8'h92, 6);
        dwell(4'hB, 8'h82, 6);
        dwell(4'h7, 8'hF8, 6);
        dwell(4'hE, 8'h80, 6);
        dwell(4'hD, 8'h90, 6);
        dwell(4'hB, 8'h88, 6);
        doReset();

        // random dwells of varied length and legality
        for (int n = 0; n < 300; n++) begin
            do begin
                ra = anTab[$urandom_range(0, 6)];
                if ($urandom_range(0, 7) == 0) rs = 8'($urandom);
                else rs = {1'($urandom), hexPat[$urandom_range(0, 15)]};
            end while (ra == prevAn && rs == prevSeg);
            dwell(ra, rs, $urandom_range(1, 10));
        end
        if (prevAn == 4'hF && prevSeg == 8'hFF) dwell(4'hF, 8'h7F, LAT + 2);
        else dwell(4'hF, 8'hFF, LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
